// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: bundles both requester ports, the memory side and busy for data_mem_arbiter
//   slave  : arbiter view (requests/mem_rdata in; grants, done, rdata, mem strobes, busy out)
//   master : requester/memory view (the mirror of slave)
interface data_mem_arbiter_if #(
   parameter int AWIDTH = 11,
   parameter int DWIDTH = 16
);
   logic              req0, we0, gnt0, done0;
   logic [AWIDTH-1:0] addr0;
   logic [DWIDTH-1:0] wdata0, rdata0;
   logic              req1, we1, gnt1, done1;
   logic [AWIDTH-1:0] addr1;
   logic [DWIDTH-1:0] wdata1, rdata1;
   logic              mem_wr, mem_rd, busy;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_wdata, mem_rdata;
   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
      output gnt0, done0, rdata0, gnt1, done1, rdata1, mem_wr, mem_rd, mem_addr, mem_wdata, busy
   );
   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
      input  gnt0, done0, rdata0, gnt1, done1, rdata1, mem_wr, mem_rd, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter onto a single-cycle data memory (IDLE -> ACCESS -> RESP)
//   clk, rst : clock and synchronous active-high reset
//   bus      : data_mem_arbiter_if.slave (req/we/addr/wdata/gnt/done/rdata per port, mem_* side, busy)
//   ARB_ROUND_ROBIN_EN : when defined, ties go to the port not granted last; otherwise port 0 wins
module data_mem_arbiter #(
   parameter int AWIDTH = 11,
   parameter int DWIDTH = 16
) (
   input logic clk,
   input logic rst,
   data_mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
   logic [1:0]        state;
   logic              win, l_we, pick, acc, rsp, start;
   logic [AWIDTH-1:0] l_addr;
   logic [DWIDTH-1:0] l_wdata, rd0, rd1;
   assign acc   = state == ACCESS;
   assign rsp   = state == RESP;
   assign start = state == IDLE && (bus.req0 || bus.req1);
`ifdef ARB_ROUND_ROBIN_EN
   logic last;
   assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
   always_ff @(posedge clk)
      if (rst) last <= 1'b1;
      else if (start) last <= pick;
`else
   assign pick = ~bus.req0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         win     <= 1'b0;
         l_we    <= 1'b0;
         l_addr  <= '0;
         l_wdata <= '0;
         rd0     <= '0;
         rd1     <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               win     <= pick;
               l_we    <= pick ? bus.we1 : bus.we0;
               l_addr  <= pick ? bus.addr1 : bus.addr0;
               l_wdata <= pick ? bus.wdata1 : bus.wdata0;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (!l_we && !win) rd0 <= bus.mem_rdata;
               if (!l_we && win) rd1 <= bus.mem_rdata;
               state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // done is masked by rst so a reset landing in RESP aborts without a completion pulse
   assign bus.gnt0      = (acc || rsp) && !win;
   assign bus.gnt1      = (acc || rsp) && win;
   assign bus.done0     = rsp && !win && !rst;
   assign bus.done1     = rsp && win && !rst;
   assign bus.rdata0    = rd0;
   assign bus.rdata1    = rd1;
   assign bus.mem_wr    = acc && l_we;
   assign bus.mem_rd    = acc && !l_we;
   assign bus.mem_addr  = acc ? l_addr : '0;
   assign bus.mem_wdata = acc ? l_wdata : '0;
   assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed plus randomized checks of data_mem_arbiter against a transaction-level model
module tb_data_mem_arbiter;
   logic clk, rst;
   data_mem_arbiter_if #(.AWIDTH(11), .DWIDTH(16)) bus();
   data_mem_arbiter #(.AWIDTH(11), .DWIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic [15:0] mem [2048];
   logic [15:0] ref_mem [2048];
   logic [15:0] exp_rd [2];
   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
   initial clk = 0;
   always #5 clk = ~clk;
   int n_cmp = 0, n_err = 0, c = 0, s = -100, n_acc = 0, n_done = 0;
   bit chk_en = 0, mlast = 1, mw = 0, mwe = 0;
   logic [10:0] ma;
   logic [15:0] mwd;
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, o, e);
      end
   endtask
   // checks the current cycle against the model, then advances the model across one clock edge
   task automatic step();
      int p;
      bit a, r, w;
      #1;
      p = c - s;
      a = p == 1;
      r = p == 2;
      if (chk_en) begin
         chk("gnt0", bus.gnt0, (a || r) && !mw);
         chk("gnt1", bus.gnt1, (a || r) && mw);
         chk("done0", bus.done0, r && !mw && !rst);
         chk("done1", bus.done1, r && mw && !rst);
         chk("mem_wr", bus.mem_wr, a && mwe);
         chk("mem_rd", bus.mem_rd, a && !mwe);
         chk("mem_addr", bus.mem_addr, a ? ma : 11'd0);
         chk("mem_wdata", bus.mem_wdata, a ? mwd : 16'd0);
         chk("busy", bus.busy, a || r);
         chk("rdata0", bus.rdata0, exp_rd[0]);
         chk("rdata1", bus.rdata1, exp_rd[1]);
         chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
         chk("strobe_excl", bus.mem_wr & bus.mem_rd, 0);
         n_done += int'(bus.done0) + int'(bus.done1);
      end
      if (a && mwe) ref_mem[ma] = mwd;
      if (rst) begin
         s = -100;
         exp_rd[0] = 0;
         exp_rd[1] = 0;
         mlast = 1;
      end else begin
         if (a && !mwe) exp_rd[mw] = ref_mem[ma];
         if (!a && !r && (bus.req0 || bus.req1)) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = (bus.req0 && bus.req1) ? !mlast : bus.req1;
`else
            w = !bus.req0;
`endif
            mlast = w;
            mw = w;
            mwe = w ? bus.we1 : bus.we0;
            ma = w ? bus.addr1 : bus.addr0;
            mwd = w ? bus.wdata1 : bus.wdata0;
            s = c;
            n_acc++;
         end
      end
      @(posedge clk);
      #1;
      c++;
      chk_en = 1;
   endtask
   task automatic drive(input bit p, input bit rq, input bit we, input logic [10:0] ad, input logic [15:0] wd);
      if (p) begin bus.req1 = rq; bus.we1 = we; bus.addr1 = ad; bus.wdata1 = wd; end
      else begin bus.req0 = rq; bus.we0 = we; bus.addr0 = ad; bus.wdata0 = wd; end
   endtask
   task automatic txn(input bit p, input bit we, input logic [10:0] ad, input logic [15:0] wd);
      drive(p, 1, we, ad, wd);
      step();
      step();
      if (p) bus.req1 = 0; else bus.req0 = 0;
      step();
   endtask
   initial begin
      for (int i = 0; i < 2048; i++) begin mem[i] = 0; ref_mem[i] = 0; end
      exp_rd[0] = 0;
      exp_rd[1] = 0;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      rst = 1;
      step();
      step();
      rst = 0;
      step();
      txn(0, 1, 11'h005, 16'hBEEF);
      txn(0, 0, 11'h005, 16'h0000);
      chk("wr_rd_rdata0", bus.rdata0, 16'hBEEF);
      txn(1, 1, 11'h7FF, 16'h1234);
      drive(1, 1, 0, 11'h7FF, 16'h0);
      step();
      drive(1, 0, 0, 11'h123, 16'h5555);
      step();
      step();
      step();
      chk("midchg_rdata1", bus.rdata1, 16'h1234);
      chk("midchg_rdata0", bus.rdata0, 16'hBEEF);
      rst = 1;
      step();
      rst = 0;
      drive(0, 1, 1, 11'h010, 16'hA000);
      drive(1, 1, 1, 11'h020, 16'hB000);
      for (int i = 0; i < 9; i++) step();
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step();
      drive(0, 1, 0, 11'h005, 16'h0);
      step();
      step();
      rst = 1;
      bus.req0 = 0;
      step();
      rst = 0;
      step();
      chk("rst_resp_rdata0", bus.rdata0, 16'h0000);
      chk("rst_resp_busy", bus.busy, 0);
      n_acc = 0;
      n_done = 0;
      for (int i = 0; i < 1000; i++) begin
         drive(0, 1'($urandom), 1'($urandom), 11'($urandom), 16'($urandom));
         drive(1, 1'($urandom), 1'($urandom), 11'($urandom), 16'($urandom));
         step();
      end
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step();
      chk("done_per_accept", n_done, n_acc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
